serial_adder: RTL and testbench

//   Parametrised bit-serial adder/subtractor built around one full-adder cell and a carry flop.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 85 ++++++++
 tb/tb_serial_adder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus for the bit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             iStart;
  logic             iSub;
  logic             iCarry;
  logic [WIDTH-1:0] iAugend;
  logic [WIDTH-1:0] iAddend;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oSum;
  logic             oCarry;

  modport master (
    output iStart, iSub, iCarry, iAugend, iAddend,
    input  oBusy, oDone, oSum, oCarry
  );

  modport slave (
    input  iStart, iSub, iCarry, iAugend, iAddend,
    output oBusy, oDone, oSum, oCarry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// WIDTH busy cycles followed by a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           iClk,
  input logic           iRst,
  serial_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] sumReg;
  logic             carry;
  logic             carryReg;
  logic [CNT_W-1:0] bitCnt;
  logic             bitSum;
  logic             bitCarry;
  logic [WIDTH:0]   resCat;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Full-adder cell; the new sum bit enters the result from the MSB side.
  always_comb begin
    bitSum   = opA[0] ^ opB[0] ^ carry;
    bitCarry = majority(opA[0], opB[0], carry);
    resCat   = {bitSum, result};
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      opA      <= '0;
      opB      <= '0;
      result   <= '0;
      sumReg   <= '0;
      carry    <= 1'b0;
      carryReg <= 1'b0;
      bitCnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.iStart) begin
            // Subtraction is A + ~B + 1, so the inverted operand and forced carry load here.
            opA    <= bus.iAugend;
            opB    <= bus.iSub ? ~bus.iAddend : bus.iAddend;
            carry  <= bus.iSub ? 1'b1 : bus.iCarry;
            bitCnt <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          opA    <= opA >> 1;
          opB    <= opB >> 1;
          carry  <= bitCarry;
          result <= resCat[WIDTH:1];
          bitCnt <= bitCnt + CNT_W'(1);
          if (bitCnt == LAST_BIT) begin
            sumReg   <= resCat[WIDTH:1];
            carryReg <= bitCarry;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oBusy  = (state == RUN);
  assign bus.oDone  = (state == DONE);
  assign bus.oSum   = sumReg;
  assign bus.oCarry = carryReg;
endmodule

// File: tb/tb_serial_adder.sv
// Randomised and exhaustive bench for serial_adder at WIDTH 1, 3 and 4
// against an arithmetic {carry,sum} reference.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  int   nTests = 0;
  int   nFail  = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(1)) bus1();
  serial_adder_if #(.WIDTH(3)) bus3();
  serial_adder_if #(.WIDTH(4)) bus4();

  serial_adder #(.WIDTH(1)) dut1 (.iClk(clk), .iRst(rst), .bus(bus1));
  serial_adder #(.WIDTH(3)) dut3 (.iClk(clk), .iRst(rst), .bus(bus3));
  serial_adder #(.WIDTH(4)) dut4 (.iClk(clk), .iRst(rst), .bus(bus4));

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact unsigned arithmetic, returns {carry,sum} as one number.
  function automatic logic [31:0] refResult(input int w, input logic sub, input logic cin,
                                            input int a, input int b);
    int mask = (1 << w) - 1;
    int s;
    int c;
    if (sub) begin
      s = (a - b) & mask;
      c = (a >= b) ? 1 : 0;
    end else begin
      s = (a + b + int'(cin)) & mask;
      c = (a + b + int'(cin)) >> w;
    end
    return 32'((c << w) | s);
  endfunction

  function automatic logic [31:0] getSum(input int w);
    case (w)
      1:       return 32'(bus1.oSum);
      3:       return 32'(bus3.oSum);
      default: return 32'(bus4.oSum);
    endcase
  endfunction

  function automatic logic [31:0] getCarry(input int w);
    case (w)
      1:       return 32'(bus1.oCarry);
      3:       return 32'(bus3.oCarry);
      default: return 32'(bus4.oCarry);
    endcase
  endfunction

  function automatic logic [31:0] getBusy(input int w);
    case (w)
      1:       return 32'(bus1.oBusy);
      3:       return 32'(bus3.oBusy);
      default: return 32'(bus4.oBusy);
    endcase
  endfunction

  function automatic logic [31:0] getDone(input int w);
    case (w)
      1:       return 32'(bus1.oDone);
      3:       return 32'(bus3.oDone);
      default: return 32'(bus4.oDone);
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input logic sub, input logic cin,
                       input logic [3:0] a, input logic [3:0] b);
    case (w)
      1: begin
        bus1.iStart = st; bus1.iSub = sub; bus1.iCarry = cin;
        bus1.iAugend = a[0:0]; bus1.iAddend = b[0:0];
      end
      3: begin
        bus3.iStart = st; bus3.iSub = sub; bus3.iCarry = cin;
        bus3.iAugend = a[2:0]; bus3.iAddend = b[2:0];
      end
      default: begin
        bus4.iStart = st; bus4.iSub = sub; bus4.iCarry = cin;
        bus4.iAugend = a; bus4.iAddend = b;
      end
    endcase
  endtask

  task automatic scramble(input int w);
    drive(w, 1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
  endtask

  // One complete request: latency, pulse width, result and hold.
  task automatic runOp(input int w, input logic sub, input logic cin,
                       input int a, input int b, input string tag);
    int mask = (1 << w) - 1;
    int busyCnt = 0;
    int cyc = 0;
    logic [31:0] r;
    r = refResult(w, sub, cin, a & mask, b & mask);
    @(negedge clk);
    drive(w, 1'b1, sub, cin, 4'(a), 4'(b));
    @(negedge clk);
    scramble(w);
    while (getDone(w) !== 32'd1 && cyc < 4 * w + 8) begin
      if (getBusy(w) === 32'd1) busyCnt++;
      @(negedge clk);
      cyc++;
    end
    checkVal({tag, ".busyCycles"}, 32'(busyCnt), 32'(w));
    checkVal({tag, ".done"}, getDone(w), 32'd1);
    checkVal({tag, ".busyWithDone"}, getBusy(w), 32'd0);
    checkVal({tag, ".sum"}, getSum(w), r & 32'(mask));
    checkVal({tag, ".carry"}, getCarry(w), r >> w);
    @(negedge clk);
    checkVal({tag, ".pulse"}, getDone(w), 32'd0);
    checkVal({tag, ".hold"}, getSum(w), r & 32'(mask));
  endtask

  initial begin
    int cyc;
    int doneCnt;
    int busyCnt;
    logic [31:0] capSum;
    logic [31:0] capCarry;

    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    drive(3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    drive(4, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    #3 rst = 1'b1;
    #1;
    for (int w = 1; w <= 4; w++) begin
      if (w == 2) continue;
      checkVal($sformatf("rst.w%0d.busy", w), getBusy(w), 32'd0);
      checkVal($sformatf("rst.w%0d.done", w), getDone(w), 32'd0);
      checkVal($sformatf("rst.w%0d.sum", w), getSum(w), 32'd0);
      checkVal($sformatf("rst.w%0d.carry", w), getCarry(w), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkVal("rst.released.busy", getBusy(4), 32'd0);

    // Directed add/sub corner cases.
    runOp(4, 1'b0, 1'b0, 5, 3, "t1.add5p3");
    runOp(4, 1'b0, 1'b0, 15, 1, "t2.add15p1");
    runOp(4, 1'b0, 1'b1, 0, 0, "t2.add0p0c1");
    runOp(4, 1'b1, 1'b0, 5, 3, "t3.sub5m3c0");
    runOp(4, 1'b1, 1'b1, 5, 3, "t3.sub5m3c1");
    runOp(4, 1'b1, 1'b0, 3, 5, "t3.sub3m5c0");
    runOp(4, 1'b1, 1'b1, 3, 5, "t3.sub3m5c1");

    // Request while busy is ignored; request in DONE runs back-to-back.
    @(negedge clk);
    drive(4, 1'b1, 1'b0, 1'b0, 4'd5, 4'd3);
    @(negedge clk);
    drive(4, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    drive(4, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9);
    @(negedge clk);
    drive(4, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc = 0;
    while (getDone(4) !== 32'd1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkVal("t4.first.done", getDone(4), 32'd1);
    checkVal("t4.first.sum", getSum(4), 32'd8);
    checkVal("t4.first.carry", getCarry(4), 32'd0);
    drive(4, 1'b1, 1'b0, 1'b1, 4'd2, 4'd6);
    doneCnt = 0;
    busyCnt = 0;
    capSum = '0;
    capCarry = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) scramble(4);
      if (getBusy(4) === 32'd1) busyCnt++;
      if (getDone(4) === 32'd1) begin
        doneCnt++;
        capSum = getSum(4);
        capCarry = getCarry(4);
      end
    end
    checkVal("t4.second.doneCount", 32'(doneCnt), 32'd1);
    checkVal("t4.second.busyCycles", 32'(busyCnt), 32'd4);
    checkVal("t4.second.sum", capSum, 32'd9);
    checkVal("t4.second.carry", capCarry, 32'd0);

    // Asynchronous reset in the middle of a run.
    runOp(4, 1'b0, 1'b0, 15, 2, "t5.pre");
    @(negedge clk);
    drive(4, 1'b1, 1'b0, 1'b0, 4'd9, 4'd5);
    @(negedge clk);
    drive(4, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    checkVal("t5.busyBeforeRst", getBusy(4), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkVal("t5.rst.busy", getBusy(4), 32'd0);
    checkVal("t5.rst.sum", getSum(4), 32'd0);
    checkVal("t5.rst.carry", getCarry(4), 32'd0);
    checkVal("t5.rst.done", getDone(4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doneCnt = 0;
    busyCnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (getDone(4) === 32'd1) doneCnt++;
      if (getBusy(4) === 32'd1) busyCnt++;
    end
    checkVal("t5.noDoneAfterRst", 32'(doneCnt), 32'd0);
    checkVal("t5.idleAfterRst", 32'(busyCnt), 32'd0);
    runOp(4, 1'b0, 1'b0, 7, 7, "t5.add7p7");

    // Randomised WIDTH=4 traffic.
    for (int i = 0; i < 40; i++) begin
      runOp(4, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), $sformatf("rnd4.%0d", i));
    end

    // Exhaustive WIDTH=1 and WIDTH=3.
    for (int w = 1; w <= 3; w += 2) begin
      for (int sub = 0; sub < 2; sub++)
        for (int cin = 0; cin < 2; cin++)
          for (int a = 0; a < (1 << w); a++)
            for (int b = 0; b < (1 << w); b++)
              runOp(w, 1'(sub), 1'(cin), a, b,
                    $sformatf("ex%0d.s%0dc%0d.%0d_%0d", w, sub, cin, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
